// File: rtl/data_ram_sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram_sb_pkg
//  Description : Shared constants for the data-side RAM responder:
//                bus encoding values, default array depth, big-endian
//                byte-lane indices and a byte-lane merge helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_ram_sb_pkg;

    // Bus encoding values driven by the memory-access stage
    localparam logic        RstEnable      = 1'b1;
    localparam logic        ChipEnable     = 1'b1;
    localparam logic        WriteEnable    = 1'b1;
    localparam logic [31:0] ZeroWord       = 32'h0000_0000;

    // log2 of the data memory depth in 32-bit words
    localparam int          DataMemNumLog2 = 17;

    // Big-endian lane mapping: the byte at offset 00 lives in bits 31:24
    // and is selected by sel[3]; offset 11 lives in bits 7:0 (sel[0]).
    localparam int          LaneOff00      = 3;
    localparam int          LaneOff01      = 2;
    localparam int          LaneOff10      = 1;
    localparam int          LaneOff11      = 0;
    localparam int          NumLanes       = 4;

    // Replace each lane of 'base' whose enable bit is set with the
    // matching lane of 'upd'.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] base,
        input logic [31:0] upd,
        input logic [3:0]  en
    );
        logic [31:0] res;
        res = base;
        for (int k = 0; k < NumLanes; k++) begin
            if (en[k]) begin
                res[8*k +: 8] = upd[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage : data_ram_sb_pkg
`default_nettype wire

// File: rtl/data_ram_array.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram_array
//  Description : 2^ADDR_W x 32-bit storage array. One synchronous write
//                port with four byte enables, one asynchronous read port.
//                The array has no reset; contents persist across reset.
//  Ports       : clk      - write clock
//                wr_en    - write strobe
//                wr_idx   - word index to write
//                wr_sel   - byte enables (bit k covers bits 8k+7:8k)
//                wr_data  - write data
//                rd_idx   - word index to read
//                rd_data  - asynchronous read data
//  Revision    : 1.0 - initial release
// ============================================================================
module data_ram_array
    import data_ram_sb_pkg::*;
#(
    parameter int ADDR_W = DataMemNumLog2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [3:0]        wr_sel,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [31:0]       rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] r_mem [0:DEPTH-1];

    // Byte-granular write: only enabled lanes change.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < NumLanes; k++) begin
                if (wr_sel[k]) begin
                    r_mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    assign rd_data = r_mem[rd_idx];

endmodule : data_ram_array
`default_nettype wire

// File: rtl/data_ram_sb.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram_sb
//  Description : Data-side RAM responder for the memory-access stage.
//                Stores are captured into a one-entry store buffer and
//                committed to the array on the following edge. Loads are
//                combinational and merge any matching buffered bytes, so a
//                store is visible to the very next load.
//  Ports       : clk         - system clock
//                rst         - synchronous active-high reset
//                ce          - chip enable
//                we          - write enable (valid when ce = 1)
//                addr        - byte address; addr[ADDR_W+1:2] is used
//                sel         - big-endian byte-lane select for stores
//                data_i      - store data (lane-replicated by the stage)
//                data_o      - load data word (zero unless loading)
//                sb_valid_o  - store buffer holds an uncommitted store
//                store_cnt_o - number of accepted stores (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module data_ram_sb
    import data_ram_sb_pkg::*;
#(
    parameter int ADDR_W = DataMemNumLog2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        sb_valid_o,
    output logic [31:0] store_cnt_o
);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_idx;
    logic              w_store;
    logic              w_load;
    logic              w_unused_addr_bits;

    // Out-of-range addresses alias: upper bits and the byte offset drop.
    assign w_idx              = addr[ADDR_W+1:2];
    assign w_unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

    assign w_store = (ce == ChipEnable) && (we == WriteEnable);
    assign w_load  = (ce == ChipEnable) && (we != WriteEnable);

    // ------------------------------------------------------------------
    // One-entry store buffer and store counter
    // ------------------------------------------------------------------
    logic              r_sb_valid;
    logic [ADDR_W-1:0] r_sb_idx;
    logic [3:0]        r_sb_sel;
    logic [31:0]       r_sb_data;
    logic [31:0]       r_store_cnt;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            // Pending entry is dropped, not committed (see w_commit).
            r_sb_valid  <= 1'b0;
            r_store_cnt <= ZeroWord;
        end else if (w_store) begin
            // Capture the new store; any old entry commits at this edge.
            r_sb_valid  <= 1'b1;
            r_store_cnt <= r_store_cnt + 32'd1;
        end else begin
            r_sb_valid  <= 1'b0;
        end
    end

    // Payload fields need no reset: they are qualified by r_sb_valid.
    always_ff @(posedge clk) begin
        if ((rst != RstEnable) && w_store) begin
            r_sb_idx  <= w_idx;
            r_sb_sel  <= sel;
            r_sb_data <= data_i;
        end
    end

    // ------------------------------------------------------------------
    // Commit path into the array
    // ------------------------------------------------------------------
    logic        w_commit;
    logic [31:0] w_arr_rdata;

    // The buffered entry always drains on the edge after capture unless
    // reset lands on that edge, in which case it is discarded.
    assign w_commit = r_sb_valid && (rst != RstEnable);

    data_ram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (w_commit),
        .wr_idx  (r_sb_idx),
        .wr_sel  (r_sb_sel),
        .wr_data (r_sb_data),
        .rd_idx  (w_idx),
        .rd_data (w_arr_rdata)
    );

    // ------------------------------------------------------------------
    // Load path with store-buffer bypass
    // ------------------------------------------------------------------
    logic        w_hit;
    logic [3:0]  w_byp_sel;
    logic [31:0] w_load_word;

    // A buffered entry still pending commit covers only its selected lanes.
    assign w_hit       = r_sb_valid && (r_sb_idx == w_idx);
    assign w_byp_sel   = w_hit ? r_sb_sel : 4'b0000;
    assign w_load_word = merge_lanes(w_arr_rdata, r_sb_data, w_byp_sel);

    always_comb begin
        data_o = ZeroWord;
        if (w_load) begin
            data_o = w_load_word;
        end
    end

    assign sb_valid_o  = r_sb_valid;
    assign store_cnt_o = r_store_cnt;

endmodule : data_ram_sb
`default_nettype wire
